// File: rtl/unidade_controle_jogo.sv
`default_nettype none
// ===========================================================================
// unidade_controle_jogo : Moore control FSM for the memory-game datapath.
// Optional ESPERA timeout enabled by defining UC_TIMEOUT_EN.  Rev 1.0
// ===========================================================================
module unidade_controle_jogo #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TO_WIDTH       = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
`ifdef UC_TIMEOUT_EN
    FIM_TIMEOUT = 4'hD,
`endif
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hE
  } state_t;

  state_t state;
  state_t next;

  generate
    if (TIMEOUT_CYCLES < 2 || (64'(1) << TO_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_param_check
      $error("unidade_controle_jogo: TIMEOUT_CYCLES must be >= 2 and fit in TO_WIDTH bits");
    end
  endgenerate

`ifdef UC_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt;
  logic                timeout_hit;

  assign timeout_hit = (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside ESPERA, so every entry starts from 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != ESPERA) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    next = INICIAL;
    case (state)
      INICIAL:  next = iniciar ? PREPARA : INICIAL;
      PREPARA:  next = ESPERA;
      ESPERA: begin
        if (jogada) begin
          next = REGISTRA;
`ifdef UC_TIMEOUT_EN
        end else if (timeout_hit) begin
          next = FIM_TIMEOUT;
`endif
        end else begin
          next = ESPERA;
        end
      end
      REGISTRA: next = COMPARA;
      // A miss outranks end of memory.
      COMPARA: begin
        if (!igual)   next = FIM_ERRO;
        else if (fim) next = FIM_ACERTO;
        else          next = PROXIMO;
      end
      PROXIMO:  next = ESPERA;
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: next = iniciar ? PREPARA : FIM_TIMEOUT;
`endif
      FIM_ACERTO: next = iniciar ? PREPARA : FIM_ACERTO;
      FIM_ERRO:   next = iniciar ? PREPARA : FIM_ERRO;
      default:    next = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INICIAL;
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
    end else begin
      state     <= next;
      zeraC     <= (next == PREPARA);
      contaC    <= (next == PROXIMO);
      zeraR     <= (next == PREPARA);
      registraR <= (next == REGISTRA);
      acertou   <= (next == FIM_ACERTO);
`ifdef UC_TIMEOUT_EN
      pronto    <= (next == FIM_ACERTO) || (next == FIM_ERRO) || (next == FIM_TIMEOUT);
      errou     <= (next == FIM_ERRO) || (next == FIM_TIMEOUT);
`else
      pronto    <= (next == FIM_ACERTO) || (next == FIM_ERRO);
      errou     <= (next == FIM_ERRO);
`endif
    end
  end

`ifdef UC_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) timeout <= 1'b0;
    else       timeout <= (next == FIM_TIMEOUT);
  end
`else
  assign timeout = 1'b0;
`endif

  assign db_estado = state;

endmodule
`default_nettype wire
